// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer onto a single-port synchronous RAM; define MEM_ARB_RR_EN for round-robin ties
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req0_cmd,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic [DW-1:0] req0_rdata,
  input  logic [1:0]    req1_cmd,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          grant
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, ACK = 2'd3;
  localparam logic [1:0] MREAD = 2'b01, MWRITE = 2'b10;
  logic [1:0]    state, lat_cmd;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          req0, req1, win;
  // 01 and 10 are the only real commands; 00 and 11 both mean "no request"
  assign req0 = ^req0_cmd;
  assign req1 = ^req1_cmd;
`ifdef MEM_ARB_RR_EN
  logic last_grant;
  assign win = req1 & (~req0 | ~last_grant);
  // remember who was served last so a tie goes to the other port
  always_ff @(posedge clk)
    if (reset) last_grant <= 1'b1;
    else if (state == ACK) last_grant <= grant;
`else
  assign win = req1 & ~req0;
`endif
  // sequencer: latch winner in IDLE, access RAM in ISSUE, capture read data, acknowledge
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      lat_cmd    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else
      case (state)
        IDLE: if (req0 | req1) begin
          grant     <= win;
          lat_cmd   <= win ? req1_cmd : req0_cmd;
          lat_addr  <= win ? req1_addr : req0_addr;
          lat_wdata <= win ? req1_wdata : req0_wdata;
          state     <= ISSUE;
        end
        ISSUE: state <= lat_cmd == MWRITE ? ACK : CAPTURE;
        CAPTURE: begin
          if (grant) req1_rdata <= ram_rdata;
          else req0_rdata <= ram_rdata;
          state <= ACK;
        end
        default: state <= IDLE;
      endcase
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign ram_we    = (state == ISSUE) & (lat_cmd == MWRITE) & ~reset;
  assign ram_re    = (state == ISSUE) & (lat_cmd == MREAD) & ~reset;
  assign busy      = state != IDLE;
  assign req0_ack  = (state == ACK) & ~grant & ~reset;
  assign req1_ack  = (state == ACK) & grant & ~reset;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random two-port traffic against a transaction-timeline model, plus reset and idle-command cases
module tb_mem_arbiter;
  localparam int AW = 9, DW = 16;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0]    p_cmd [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic          req0_ack, req1_ack, ram_we, ram_re, busy, grant;
  logic [DW-1:0] req0_rdata, req1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_mem [1<<AW];
  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_cmd(p_cmd[0]), .req0_addr(p_addr[0]), .req0_wdata(p_wdata[0]),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req1_cmd(p_cmd[1]), .req1_addr(p_addr[1]), .req1_wdata(p_wdata[1]),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .busy(busy), .grant(grant)
  );
  // behavioural RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end
  int checks = 0, passed = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // model: one transaction at a time, timed from the IDLE cycle that sampled it
  logic [DW-1:0] mem_m [1<<AW];
  logic [DW-1:0] exp_rd [2];
  bit            act, lg, stop_new;
  bit            done [2];
  int            cyc, t0, wp;
  logic [1:0]    wcmd;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdat;
  function automatic bit reqing(input logic [1:0] c);
    return c == 2'b01 || c == 2'b10;
  endfunction
  task automatic step();
    int off, len, r;
    bit fin, r0, r1, w;
    logic [1:0] ea;
    logic ewe, ere;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++)
      if (done[p] || !reqing(p_cmd[p])) begin
        r = stop_new ? 0 : int'($urandom_range(0, 5));
        p_cmd[p]   = r == 0 ? 2'b00 : r == 1 ? 2'b11 : r < 4 ? 2'b01 : 2'b10;
        p_addr[p]  = AW'($urandom_range(0, 15));
        p_wdata[p] = DW'($urandom);
        done[p]    = 0;
      end
    ea = 2'b00; ewe = 0; ere = 0; fin = 0;
    if (act) begin
      off = cyc - t0;
      len = wcmd == 2'b10 ? 3 : 4;
      chk("grant", grant, wp);
      chk("busy_active", busy, 1);
      if (off == 1) begin
        ewe = wcmd == 2'b10;
        ere = wcmd == 2'b01;
        chk("ram_addr", ram_addr, waddr);
        if (ewe) chk("ram_wdata", ram_wdata, wdat);
      end
      if (off == len - 1) begin
        ea[wp] = 1'b1;
        if (wcmd == 2'b10) mem_m[waddr] = wdat;
        else exp_rd[wp] = mem_m[waddr];
        act = 0; fin = 1; done[wp] = 1; lg = wp[0];
      end
    end else chk("busy_idle", busy, 0);
    chk("acks", {req1_ack, req0_ack}, ea);
    chk("ram_we", ram_we, ewe);
    chk("ram_re", ram_re, ere);
    chk("rdata0", req0_rdata, exp_rd[0]);
    chk("rdata1", req1_rdata, exp_rd[1]);
    if (!act && !fin) begin
      r0 = reqing(p_cmd[0]);
      r1 = reqing(p_cmd[1]);
`ifdef MEM_ARB_RR_EN
      w = r1 && (!r0 || !lg);
`else
      w = r1 && !r0;
`endif
      if (r0 || r1) begin
        act = 1; t0 = cyc; wp = int'(w);
        wcmd = p_cmd[wp]; waddr = p_addr[wp]; wdat = p_wdata[wp];
      end
    end
  endtask
  logic [DW-1:0] old;
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = DW'($urandom);
      mem_m[i] = ram_mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      p_cmd[p] = 2'b00; p_addr[p] = '0; p_wdata[p] = '0; done[p] = 0; exp_rd[p] = '0;
    end
    act = 0; lg = 1; stop_new = 0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {req1_ack, req0_ack}, 0);
    chk("rst_en", {ram_we, ram_re}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", {req1_rdata, req0_rdata}, 0);
    reset = 0;
    repeat (1500) step();
    stop_new = 1;
    repeat (40) step();
    chk("drained", act, 0);
    // reset during ISSUE of a port 0 write
    @(posedge clk);
    #1;
    old = ram_mem[9'h033];
    p_cmd[0] = 2'b10; p_addr[0] = 9'h033; p_wdata[0] = ~old; p_cmd[1] = 2'b00;
    @(posedge clk);
    #1;
    chk("issue_busy", busy, 1);
    reset = 1;
    p_cmd[0] = 2'b00;
    #1;
    chk("rst_issue_we", ram_we, 0);
    @(posedge clk);
    #1;
    reset = 0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rdata0", req0_rdata, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_acks", {req1_ack, req0_ack}, 0);
    end
    chk("ram_unchanged", ram_mem[9'h033], old);
    // 11 on port 0 is not a request
    p_cmd[0] = 2'b11; p_cmd[1] = 2'b00;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("cmd11_busy", busy, 0);
      chk("cmd11_en", {ram_we, ram_re}, 0);
      chk("cmd11_acks", {req1_ack, req0_ack}, 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port 16-bit data/instruction RAM. Port 0 is the CPU memory interface (`mem_cmd`/`mem_addr`/`out`); port 1 is a secondary master (program loader or DMA). The block serialises their accesses onto one RAM with a synchronous read, returns read data and a one-cycle acknowledge to the winning port, and sits between the `cpu` top level and the RAM instance.

## Interface
Parameters:
- `AW`, default 9: address width; matches the CPU `mem_addr`.
- `DW`, default 16: data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_cmd`  in  2  port 0 command: 00 none, 01 MREAD, 10 MWRITE, 11 ignored (treated as none).
- `req0_addr`  in  AW  port 0 address.
- `req0_wdata`  in  DW  port 0 write data.
- `req0_ack`  out  1  one-cycle completion pulse for port 0.
- `req0_rdata`  out  DW  port 0 read data; valid with `req0_ack` on reads and held until the next port 0 read completes.
- `req1_cmd`, `req1_addr`, `req1_wdata`, `req1_ack`, `req1_rdata`: port 1 equivalents, with identical widths and meanings.
- `ram_addr`  out  AW  RAM address.
- `ram_wdata`  out  DW  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_re`  out  1  RAM read enable; data appears on `ram_rdata` the following cycle.
- `ram_rdata`  in  DW  RAM read data.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  index of the port currently being served; holds its last value while in IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- **IDLE:**
  - A port is requesting when its cmd is 01 or 10.
  - If any port is requesting, select a winner and latch that port's cmd, addr and wdata into internal registers. Set `grant`, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:**
  - `ram_addr` and `ram_wdata` are driven from the latched registers.
  - Write: `ram_we=1`, next state ACK.
  - Read: `ram_re=1`, next state CAPTURE.
- **CAPTURE:** `ram_rdata` is registered into the granted port's rdata register. Next state ACK.
- **ACK:** `reqN_ack=1` for the granted port only. Next state IDLE.
- **Requester rule:** cmd, addr and wdata stay stable from assertion until the edge that ends the ack cycle. On that edge the requester either drops cmd or presents its next command, which the arbiter samples in the following IDLE cycle. Changing cmd or addr before ack is a protocol violation; the arbiter uses the latched copy and ignores the change.
- **Arbitration:**
  - Fixed priority by default: port 0 wins a tie.
  - A lone requester always wins.
- **Output gating:** `ram_we` and `ram_re` are each the decoded state AND `~reset`, so no RAM access is issued in a reset cycle.
- **Reset values:**
  - State goes to IDLE.
  - All acks, `ram_we`, `ram_re` and `busy` are 0.
  - `grant`, both rdata registers, and the latched cmd/addr/wdata are 0.
  - `ram_addr` and `ram_wdata` are 0.
- **Reset mid-operation:** the in-flight transaction is dropped. No ack is issued for it and rdata is not updated. The requester must re-issue after reset.

## Timing
- Request sampled in IDLE cycle T.
- Write: `ram_we` is high in T+1 and `ack` is high in T+2. Total 3 cycles per write.
- Read: `ram_re` is high in T+1, `ram_rdata` is captured at the end of T+2, and `ack` and rdata are valid in T+3. Total 4 cycles per read.
- Back-to-back requests from one port: the next IDLE sample falls in the cycle after ack, so there are no idle gaps beyond the IDLE cycle itself.
- At most one RAM access is outstanding; `ram_we` and `ram_re` are never high together.
- Both acks are never high in the same cycle.

## Configuration
- `MEM_ARB_RR_EN`: when defined, round-robin arbitration is used.
  - A one-bit `last_grant` register is updated in ACK. On a tie, the port not equal to `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie after reset.
- Without `MEM_ARB_RR_EN`: fixed priority, port 0 always wins ties, and port 1 may starve under continuous port 0 traffic.

## Test plan
- Port 0 MREAD of addr 0x005, RAM word 0x5A3C, port 1 idle -> `ram_re` high in T+1 with `ram_addr`=0x005; `req0_ack` high in T+3 with `req0_rdata`=0x5A3C; `grant`=0.
- Port 1 MWRITE of 0xBEEF to addr 0x1F0 -> `ram_we` high for exactly one cycle in T+1 with `ram_addr`=0x1F0 and `ram_wdata`=0xBEEF; `req1_ack` high in T+2; a following port 0 read of 0x1F0 returns 0xBEEF.
- Both ports issue MREAD continuously, fixed priority -> only `req0_ack` pulses, every 4 cycles. With `MEM_ARB_RR_EN` -> acks alternate 0,1,0,1, with port 0 first after reset.
- Port 0 MWRITE, with `reset` asserted in the ISSUE cycle -> `ram_we` stays 0 in that cycle, no ack is issued, and the RAM location is unchanged; the next cycle is in IDLE with `busy`=0.
- `req0_cmd`=11 and `req1_cmd`=00 for 10 cycles -> state stays IDLE with `busy`=0, no RAM enables and no acks.
- Port 0 read followed by a port 1 read of a different address -> `req0_rdata` holds its value through the port 1 transaction; only `req1_rdata` updates.
